cr_huf_comp_sa_short_rd: RTL and testbench

CR_HUF_COMP_SA_SHORT_RD -- requirements
Module: cr_huf_comp_sa_short_rd

---
 rtl/cr_huf_comp_sa_short_rd.sv | 165 ++++++++++++++++
 tb/tb_cr_huf_comp_sa_short_rd.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_huf_comp_sa_short_rd.sv
// Purpose: issues short-symbol LUT reads per input beat and packs the returned {len, code} lanes LSB-first into one output beat.
// Latency: one cycle from lut_data_val to out_valid; issue-to-data latency is set by the table and is unbounded.
// Backpressure: one read in flight at a time; a held output beat blocks the next issue, which may go out on the accept cycle.
module cr_huf_comp_sa_short_rd #(
  parameter int ADDR_W = 9,
  parameter int CODE_W = 15,
  parameter int LEN_W  = 4,
  parameter int SEQ_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  input  logic [2:0]              sym_cnt,
  input  logic                    sym_last,
  input  logic [ADDR_W-1:0]       sym_addr0,
  input  logic [ADDR_W-1:0]       sym_addr1,
  input  logic [ADDR_W-1:0]       sym_addr2,
  input  logic [ADDR_W-1:0]       sym_addr3,
  input  logic                    lut_hw_vld,
  input  logic                    lut_data_val,
  input  logic [CODE_W+LEN_W-1:0] lut_rd_data0,
  input  logic [CODE_W+LEN_W-1:0] lut_rd_data1,
  input  logic [CODE_W+LEN_W-1:0] lut_rd_data2,
  input  logic [CODE_W+LEN_W-1:0] lut_rd_data3,
  output logic                    sa_lut_data_rd,
  output logic [ADDR_W-1:0]       sa_lut_data_addr0,
  output logic [ADDR_W-1:0]       sa_lut_data_addr1,
  output logic [ADDR_W-1:0]       sa_lut_data_addr2,
  output logic [ADDR_W-1:0]       sa_lut_data_addr3,
  output logic [SEQ_W-1:0]        sa_lut_seq_id,
  output logic                    sa_lut_ret_ack,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [59:0]             out_bits,
  output logic [5:0]              out_len,
  output logic                    out_last,
  output logic                    err_sym,
  output logic                    err_val
);

  localparam int DW = CODE_W + LEN_W;

  typedef enum logic [1:0] {IDLE, WAIT_TBL, RUN, ACK} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              issue;
  logic              outst;
  logic [2:0]        cnt_q;
  logic              last_q;
  logic [DW-1:0]     lane [4];
  logic [LEN_W-1:0]  len_i;
  logic [59:0]       word;
  logic [59:0]       pack_bits;
  logic [5:0]        pack_len;
  logic              pack_err;

  assign lane[0] = lut_rd_data0;
  assign lane[1] = lut_rd_data1;
  assign lane[2] = lut_rd_data2;
  assign lane[3] = lut_rd_data3;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: the block ends only once its final beat leaves the output register.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (sym_valid)  state_nxt = WAIT_TBL;
      WAIT_TBL: if (lut_hw_vld) state_nxt = RUN;
      RUN:      if (out_valid && out_ready && out_last) state_nxt = ACK;
      ACK:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs: issue needs an empty (or emptying) output register; never issue past a held last beat.
  always_comb begin
    issue = 1'b0;
    if (!rst && state == RUN && sym_valid && !outst &&
        (!out_valid || (out_ready && !out_last)))
      issue = 1'b1;
    sym_ready      = issue;
    sa_lut_data_rd = issue;
    sa_lut_ret_ack = !rst && (state == ACK);
  end

  // Pack lanes LSB-first; lanes beyond the captured count and bits above each length are dropped.
  always_comb begin
    pack_bits = '0;
    pack_len  = '0;
    pack_err  = 1'b0;
    len_i     = '0;
    word      = '0;
    for (int i = 0; i < 4; i++) begin
      len_i = lane[i][DW-1:CODE_W];
      if (3'(i) >= cnt_q) len_i = '0;
      else if (len_i == '0) pack_err = 1'b1;
      word = '0;
      word[CODE_W-1:0] = lane[i][CODE_W-1:0];
      word = word & ((60'd1 << len_i) - 60'd1);
      pack_bits = pack_bits | (word << pack_len);
      pack_len  = pack_len + 6'(len_i);
    end
  end

  // Read tracking: capture beat fields on issue, clear the in-flight flag when data returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      outst             <= 1'b0;
      cnt_q             <= '0;
      last_q            <= 1'b0;
      sa_lut_data_addr0 <= '0;
      sa_lut_data_addr1 <= '0;
      sa_lut_data_addr2 <= '0;
      sa_lut_data_addr3 <= '0;
    end else if (issue) begin
      outst             <= 1'b1;
      cnt_q             <= sym_cnt;
      last_q            <= sym_last;
      sa_lut_data_addr0 <= sym_addr0;
      sa_lut_data_addr1 <= sym_addr1;
      sa_lut_data_addr2 <= sym_addr2;
      sa_lut_data_addr3 <= sym_addr3;
    end else if (lut_data_val) begin
      outst <= 1'b0;
    end
  end

  // Output register: loaded by expected read data, emptied by the consumer handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_len   <= '0;
      out_last  <= 1'b0;
    end else if (lut_data_val && outst) begin
      out_valid <= 1'b1;
      out_bits  <= pack_bits;
      out_len   <= pack_len;
      out_last  <= last_q;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky error flags and the block sequence id, which advances as the table is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sym       <= 1'b0;
      err_val       <= 1'b0;
      sa_lut_seq_id <= '0;
    end else begin
      if (lut_data_val && outst && pack_err) err_sym <= 1'b1;
      if (lut_data_val && !outst)            err_val <= 1'b1;
      if (state == ACK) sa_lut_seq_id <= sa_lut_seq_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_cr_huf_comp_sa_short_rd.sv
// Bench for cr_huf_comp_sa_short_rd: directed beats with hand-computed packed results.
// Expected beats are queued at data-return time and popped by a monitor on each accepted output.
module tb_cr_huf_comp_sa_short_rd;

  logic        clk;
  logic        rst;
  logic        sym_valid;
  logic        sym_ready;
  logic [2:0]  sym_cnt;
  logic        sym_last;
  logic [8:0]  sym_addr0, sym_addr1, sym_addr2, sym_addr3;
  logic        lut_hw_vld;
  logic        lut_data_val;
  logic [18:0] lut_rd_data0, lut_rd_data1, lut_rd_data2, lut_rd_data3;
  logic        sa_lut_data_rd;
  logic [8:0]  sa_lut_data_addr0, sa_lut_data_addr1, sa_lut_data_addr2, sa_lut_data_addr3;
  logic [3:0]  sa_lut_seq_id;
  logic        sa_lut_ret_ack;
  logic        out_valid;
  logic        out_ready;
  logic [59:0] out_bits;
  logic [5:0]  out_len;
  logic        out_last;
  logic        err_sym;
  logic        err_val;

  int          checks;
  int          passes;
  logic [66:0] sb [$];
  logic [66:0] e;
  logic [3:0]  exp_seq;

  cr_huf_comp_sa_short_rd dut (
    .clk(clk), .rst(rst),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_cnt(sym_cnt), .sym_last(sym_last),
    .sym_addr0(sym_addr0), .sym_addr1(sym_addr1), .sym_addr2(sym_addr2), .sym_addr3(sym_addr3),
    .lut_hw_vld(lut_hw_vld), .lut_data_val(lut_data_val),
    .lut_rd_data0(lut_rd_data0), .lut_rd_data1(lut_rd_data1),
    .lut_rd_data2(lut_rd_data2), .lut_rd_data3(lut_rd_data3),
    .sa_lut_data_rd(sa_lut_data_rd),
    .sa_lut_data_addr0(sa_lut_data_addr0), .sa_lut_data_addr1(sa_lut_data_addr1),
    .sa_lut_data_addr2(sa_lut_data_addr2), .sa_lut_data_addr3(sa_lut_data_addr3),
    .sa_lut_seq_id(sa_lut_seq_id), .sa_lut_ret_ack(sa_lut_ret_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_len(out_len), .out_last(out_last), .err_sym(err_sym), .err_val(err_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [18:0] mk(input logic [3:0] l, input logic [14:0] c);
    return {l, c};
  endfunction

  // Scoreboard monitor: every accepted output beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("out_bits", {4'd0, out_bits}, {4'd0, e[59:0]});
        chk("out_len", {58'd0, out_len}, {58'd0, e[65:60]});
        chk("out_last", {63'd0, out_last}, {63'd0, e[66]});
      end
    end
  end

  // Offer one beat, wait for its issue, then return table data after dly cycles.
  task automatic send_beat(input logic [2:0] cnt, input logic last,
                           input logic [8:0] a0, input logic [8:0] a1,
                           input logic [8:0] a2, input logic [8:0] a3,
                           input logic [18:0] d0, input logic [18:0] d1,
                           input logic [18:0] d2, input logic [18:0] d3,
                           input int dly, input logic [59:0] eb, input logic [5:0] el);
    logic ok;
    sym_valid = 1'b1; sym_cnt = cnt; sym_last = last;
    sym_addr0 = a0; sym_addr1 = a1; sym_addr2 = a2; sym_addr3 = a3;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (sym_ready) ok = 1'b1;
    end
    chk("issue_seen", {63'd0, ok}, 64'd1);
    @(posedge clk); #1;
    sym_valid = 1'b0;
    chk("rd_addr", {28'd0, sa_lut_data_addr3, sa_lut_data_addr2, sa_lut_data_addr1, sa_lut_data_addr0},
        {28'd0, a3, a2, a1, a0});
    repeat (dly) @(posedge clk);
    #1;
    lut_data_val = 1'b1;
    lut_rd_data0 = d0; lut_rd_data1 = d1; lut_rd_data2 = d2; lut_rd_data3 = d3;
    sb.push_back({last, el, eb});
    @(posedge clk); #1;
    lut_data_val = 1'b0;
  endtask

  // Wait for the table-release pulse and check the sequence id around it.
  task automatic await_ack();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      if (sa_lut_ret_ack) ok = 1'b1;
    end
    chk("ack_seen", {63'd0, ok}, 64'd1);
    chk("seq_during_ack", {60'd0, sa_lut_seq_id}, {60'd0, exp_seq});
    exp_seq = exp_seq + 4'd1;
    @(negedge clk);
    chk("ack_one_cycle", {63'd0, sa_lut_ret_ack}, 64'd0);
    chk("seq_after_ack", {60'd0, sa_lut_seq_id}, {60'd0, exp_seq});
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks = 0; passes = 0; exp_seq = 4'd0;
    rst = 1'b1; sym_valid = 1'b0; sym_cnt = '0; sym_last = 1'b0;
    sym_addr0 = '0; sym_addr1 = '0; sym_addr2 = '0; sym_addr3 = '0;
    lut_hw_vld = 1'b1; lut_data_val = 1'b0; out_ready = 1'b1;
    lut_rd_data0 = '0; lut_rd_data1 = '0; lut_rd_data2 = '0; lut_rd_data3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_bits_len", {out_last, out_len, 3'd0, out_bits}, 64'd0);
    chk("rst_ctrl", {60'd0, sa_lut_data_rd, sym_ready, sa_lut_ret_ack, err_sym}, 64'd0);
    chk("rst_seq_err", {59'd0, sa_lut_seq_id, err_val}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two lanes: 3'b101 then 2'b11 -> 5'b11101.
    send_beat(3'd2, 1'b1, 9'd5, 9'd7, 9'd0, 9'd0,
              mk(4'd3, 15'h5), mk(4'd2, 15'h3), mk(4'd9, 15'h1FF), mk(4'd9, 15'h1FF),
              3, 60'h1D, 6'd5);
    await_ack();

    // Four full 15-bit lanes fill all 60 bits.
    send_beat(3'd4, 1'b1, 9'd1, 9'd2, 9'd3, 9'd4,
              mk(4'd15, 15'h7FFF), mk(4'd15, 15'h7FFF), mk(4'd15, 15'h7FFF), mk(4'd15, 15'h7FFF),
              1, {60{1'b1}}, 6'd60);
    await_ack();

    // Code bits above each length are dropped; lane 3 is beyond the count.
    send_beat(3'd3, 1'b1, 9'h1FF, 9'h100, 9'h0AA, 9'h055,
              mk(4'd4, 15'hA), mk(4'd1, 15'h3), mk(4'd8, 15'h1FF), mk(4'd7, 15'h55),
              0, 60'h1FFA, 6'd13);
    await_ack();

    // Two-beat block; the second read issues as the first beat is accepted.
    send_beat(3'd4, 1'b0, 9'd10, 9'd11, 9'd12, 9'd13,
              mk(4'd1, 15'h1), mk(4'd2, 15'h2), mk(4'd3, 15'h4), mk(4'd4, 15'h8),
              2, 60'h225, 6'd10);
    send_beat(3'd1, 1'b1, 9'd20, 9'd21, 9'd22, 9'd23,
              mk(4'd6, 15'h2A), mk(4'd5, 15'h1F), mk(4'd5, 15'h1F), mk(4'd5, 15'h1F),
              1, 60'h2A, 6'd6);
    await_ack();

    // Backpressure: held beat blocks the next read for 10 cycles; table valid drops meanwhile.
    out_ready = 1'b0;
    send_beat(3'd1, 1'b0, 9'd30, 9'd0, 9'd0, 9'd0,
              mk(4'd2, 15'h2), 19'd0, 19'd0, 19'd0, 2, 60'h2, 6'd2);
    sym_valid = 1'b1; sym_cnt = 3'd1; sym_last = 1'b1; sym_addr0 = 9'd9;
    lut_hw_vld = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_no_rd", {63'd0, sa_lut_data_rd}, 64'd0);
      chk("bp_hold", {out_valid, out_len, 3'd0, out_bits[53:0]}, {1'b1, 6'd2, 3'd0, 54'h2});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rd_on_accept", {63'd0, sa_lut_data_rd}, 64'd1);
    @(posedge clk); #1;
    sym_valid = 1'b0;
    chk("bp_addr", {55'd0, sa_lut_data_addr0}, {55'd0, 9'd9});
    @(posedge clk); #1;
    lut_data_val = 1'b1; lut_rd_data0 = mk(4'd3, 15'h5);
    sb.push_back({1'b1, 6'd3, 60'h5});
    @(posedge clk); #1;
    lut_data_val = 1'b0; lut_hw_vld = 1'b1;
    await_ack();

    // Empty block, then sixteen more to wrap the sequence id.
    for (int b = 0; b < 17; b++) begin
      send_beat(3'd0, 1'b1, 9'd0, 9'd0, 9'd0, 9'd0,
                mk(4'd5, 15'h1F), mk(4'd5, 15'h1F), 19'd0, 19'd0, 1, 60'h0, 6'd0);
      await_ack();
    end

    // Stray read data while idle.
    @(negedge clk);
    chk("err_val_clean", {63'd0, err_val}, 64'd0);
    @(posedge clk); #1;
    lut_data_val = 1'b1; lut_rd_data0 = mk(4'd4, 15'hF);
    @(posedge clk); #1;
    lut_data_val = 1'b0;
    @(negedge clk);
    chk("err_val_stray", {62'd0, err_val, out_valid}, 64'd2);

    // A counted lane with zero length.
    chk("err_sym_clean", {63'd0, err_sym}, 64'd0);
    @(posedge clk); #1;
    send_beat(3'd2, 1'b1, 9'd3, 9'd4, 9'd0, 9'd0,
              mk(4'd3, 15'h6), mk(4'd0, 15'h7), 19'd0, 19'd0, 1, 60'h6, 6'd3);
    await_ack();
    chk("err_sym_set", {63'd0, err_sym}, 64'd1);

    // Reset with a read in flight, then late data.
    sym_valid = 1'b1; sym_cnt = 3'd1; sym_last = 1'b1; sym_addr0 = 9'd77;
    for (int n = 0; n < 50 && !sym_ready; n++) @(negedge clk);
    chk("mid_issue", {63'd0, sym_ready}, 64'd1);
    @(posedge clk); #1;
    sym_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_comb", {61'd0, sym_ready, sa_lut_data_rd, sa_lut_ret_ack}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_flags", {62'd0, err_sym, err_val}, 64'd0);
    chk("mid_rst_out", {out_valid, out_last, out_len[4:0], 3'd0, out_bits[53:0]}, 64'd0);
    chk("mid_rst_addr_seq", {24'd0, sa_lut_seq_id, sa_lut_data_addr3, sa_lut_data_addr2,
                             sa_lut_data_addr1, sa_lut_data_addr0}, 64'd0);
    chk("mid_rst_len_hi", {58'd0, out_len}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    lut_data_val = 1'b1; lut_rd_data0 = mk(4'd2, 15'h1);
    @(posedge clk); #1;
    lut_data_val = 1'b0;
    @(negedge clk);
    chk("late_data_err", {62'd0, err_val, out_valid}, 64'd2);

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
